// File: rtl/rx_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_ctrl_if
// Purpose  : Byte-stream link between the UART receive PHY and the frame
//            controller: a one-cycle valid strobe qualifying a received byte.
// Revision : 1.0 - initial release
// ============================================================================
interface rx_frame_ctrl_if;
  logic       rx_vld;   // one-cycle strobe, rx_data valid
  logic [7:0] rx_data;  // received byte

  // Byte producer (the receive PHY)
  modport master (
    output rx_vld,
    output rx_data
  );

  // Byte consumer (the frame controller)
  modport slave (
    input rx_vld,
    input rx_data
  );
endinterface
`default_nettype wire

// File: rtl/rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_ctrl
// Purpose  : Frame-level controller for the UART receive path. Hunts for a
//            sync byte, walks length / payload / checksum, checks the payload
//            against the selected test pattern, enforces an inter-byte
//            timeout and keeps saturating good / bad frame counters.
// Revision : 1.0 - initial release
// ============================================================================
module rx_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TO_SHIFT  = 4
) (
  input  wire logic        clk_sys,
  input  wire logic        rst_n,
  rx_frame_ctrl_if.slave   rx_if,
  input  wire logic [19:0] tbit_period,
  input  wire logic        tx_pattern,
  input  wire logic        clr,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_ok,
  output logic [31:0]      rx_total,
  output logic [31:0]      rx_err
);

  localparam int          CNT_W   = 20 + TO_SHIFT;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LEN  = 2'd1,
    PAY  = 2'd2,
    CSUM = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         len_q, len_d;
  logic               pat_q, pat_d;
  logic [7:0]         idx_q, idx_d;
  logic [7:0]         sum_q, sum_d;
  logic               mis_q, mis_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ok_q, ok_d;
  logic [31:0]        total_q, total_d;
  logic [31:0]        err_q, err_d;

  logic [CNT_W-1:0]   limit;
  logic [7:0]         exp_byte;
  logic               to_fire;
  logic               end_evt;
  logic               good_evt;

  // Timeout threshold in clk_sys cycles and the expected payload byte for the current index
  always_comb begin
    limit    = {{TO_SHIFT{1'b0}}, tbit_period} << TO_SHIFT;
    exp_byte = pat_q ? (idx_q[0] ? 8'hAA : 8'h55) : idx_q;
    to_fire  = (state_q != HUNT) && !rx_if.rx_vld && (tbit_period != 20'd0) && (cnt_q == limit);
  end

  // Next-state, field tracking, frame result and counter logic
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    pat_d    = pat_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    mis_d    = mis_q;
    end_evt  = 1'b0;
    good_evt = 1'b0;

    // Idle-cycle counter restarts on every byte and while hunting
    if (rx_if.rx_vld || (state_q == HUNT)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      HUNT: begin
        if (rx_if.rx_vld && (rx_if.rx_data == SYNC_BYTE)) begin
          state_d = LEN;
        end
      end
      LEN: begin
        if (rx_if.rx_vld) begin
          if (rx_if.rx_data == 8'd0) begin
            end_evt = 1'b1;
            state_d = HUNT;
          end else begin
            len_d   = rx_if.rx_data;
            pat_d   = tx_pattern;
            idx_d   = 8'd0;
            sum_d   = 8'd0;
            mis_d   = 1'b0;
            state_d = PAY;
          end
        end
      end
      PAY: begin
        if (rx_if.rx_vld) begin
          sum_d = sum_q + rx_if.rx_data;
          mis_d = mis_q | (rx_if.rx_data != exp_byte);
          idx_d = idx_q + 8'd1;
          // len >= 1 here, so len-1 never underflows and idx never wraps
          if (idx_q == (len_q - 8'd1)) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (rx_if.rx_vld) begin
          end_evt  = 1'b1;
          good_evt = (rx_if.rx_data == sum_q) && !mis_q;
          state_d  = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase

    // Timeout only fires on a byte-free cycle, so a byte arriving at the limit wins
    if (to_fire) begin
      end_evt  = 1'b1;
      good_evt = 1'b0;
      state_d  = HUNT;
    end

    done_d  = end_evt;
    ok_d    = end_evt ? good_evt : ok_q;
    total_d = (end_evt && good_evt && (total_q != CNT_MAX)) ? total_q + 32'd1 : total_q;
    err_d   = (end_evt && !good_evt && (err_q != CNT_MAX)) ? err_q + 32'd1 : err_q;

    // Clear overrides everything, including a byte or frame end in the same cycle
    if (clr) begin
      state_d = HUNT;
      cnt_d   = '0;
      idx_d   = 8'd0;
      sum_d   = 8'd0;
      mis_d   = 1'b0;
      done_d  = 1'b0;
      ok_d    = 1'b0;
      total_d = 32'd0;
      err_d   = 32'd0;
    end

    busy_d = (state_d != HUNT);
  end

  // State and datapath registers
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      len_q   <= 8'd0;
      pat_q   <= 1'b0;
      idx_q   <= 8'd0;
      sum_q   <= 8'd0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      total_q <= 32'd0;
      err_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      total_q <= total_d;
      err_q   <= err_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign frame_ok   = ok_q;
  assign rx_total   = total_q;
  assign rx_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_frame_ctrl
// Purpose  : Directed self-checking bench for rx_frame_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_frame_ctrl;

  logic        clk_sys;
  logic        rst_n;
  logic [19:0] tbit_period;
  logic        tx_pattern;
  logic        clr;
  logic        busy;
  logic        frame_done;
  logic        frame_ok;
  logic [31:0] rx_total;
  logic [31:0] rx_err;

  int n_checks;
  int n_err;
  int done_cnt;
  int d0;

  rx_frame_ctrl_if u_if ();

  rx_frame_ctrl #(
    .SYNC_BYTE (8'hA5),
    .TO_SHIFT  (4)
  ) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .rx_if       (u_if),
    .tbit_period (tbit_period),
    .tx_pattern  (tx_pattern),
    .clr         (clr),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_ok    (frame_ok),
    .rx_total    (rx_total),
    .rx_err      (rx_err)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Count frame_done pulses, sampled away from the active edge
  always @(negedge clk_sys) begin
    if (frame_done) done_cnt++;
  end

  // Advance to just after the next falling edge
  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One-cycle valid strobe carrying one byte
  task automatic send_byte(input logic [7:0] b);
    u_if.rx_vld  = 1'b1;
    u_if.rx_data = b;
    tick();
    u_if.rx_vld  = 1'b0;
    u_if.rx_data = 8'h00;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_err        = 0;
    done_cnt     = 0;
    rst_n        = 1'b0;
    clr          = 1'b0;
    tbit_period  = 20'd100;
    tx_pattern   = 1'b0;
    u_if.rx_vld  = 1'b0;
    u_if.rx_data = 8'h00;
    idle(3);
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_ok", {31'd0, frame_ok}, 32'd0);
    check("rst_total", rx_total, 32'd0);
    check("rst_err", rx_err, 32'd0);

    // Garbage before a frame is ignored
    send_byte(8'h11);
    send_byte(8'h22);
    tick();
    check("garbage_busy", {31'd0, busy}, 32'd0);
    check("garbage_done", done_cnt, 0);

    // Good incrementing frame
    send_byte(8'hA5);
    check("inc_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h04);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h06);
    check("inc_pulse", {31'd0, frame_done}, 32'd1);
    tick();
    check("inc_pulse_low", {31'd0, frame_done}, 32'd0);
    check("inc_done", done_cnt, 1);
    check("inc_ok", {31'd0, frame_ok}, 32'd1);
    check("inc_total", rx_total, 32'd1);
    check("inc_err", rx_err, 32'd0);
    check("inc_busy_end", {31'd0, busy}, 32'd0);

    // Good alternating frame; pattern select flips mid-frame and must be ignored
    tx_pattern = 1'b1;
    send_byte(8'hA5); send_byte(8'h03);
    tx_pattern = 1'b0;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h55);
    send_byte(8'h54);
    tick();
    check("alt_ok", {31'd0, frame_ok}, 32'd1);
    check("alt_total", rx_total, 32'd2);

    // Same frame with a wrong checksum
    tx_pattern = 1'b1;
    send_byte(8'hA5); send_byte(8'h03);
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h55);
    send_byte(8'h00);
    tick();
    check("csum_ok", {31'd0, frame_ok}, 32'd0);
    check("csum_err", rx_err, 32'd1);
    check("csum_total", rx_total, 32'd2);

    // Pattern mismatch with a matching checksum
    tx_pattern = 1'b0;
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h02);
    tick();
    check("mis_ok", {31'd0, frame_ok}, 32'd0);
    check("mis_err", rx_err, 32'd2);

    // Zero length
    d0 = done_cnt;
    send_byte(8'hA5); send_byte(8'h00);
    tick();
    check("len0_done", done_cnt, d0 + 1);
    check("len0_err", rx_err, 32'd3);
    check("len0_busy", {31'd0, busy}, 32'd0);

    // Timeout: 10 clocks per bit, 160 idle clocks
    tbit_period = 20'd10;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
    d0 = done_cnt;
    idle(150);
    check("to_early_done", done_cnt, d0);
    check("to_early_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 40 && done_cnt == d0; i++) tick();
    check("to_done", done_cnt, d0 + 1);
    check("to_ok", {31'd0, frame_ok}, 32'd0);
    check("to_err", rx_err, 32'd4);
    check("to_busy", {31'd0, busy}, 32'd0);

    // Timeout disabled: long idle keeps the frame open, then it completes
    tbit_period = 20'd0;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00);
    d0 = done_cnt;
    idle(10000);
    check("nto_done", done_cnt, d0);
    check("nto_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    tick();
    check("nto_ok", {31'd0, frame_ok}, 32'd1);
    check("nto_total", rx_total, 32'd3);

    // Asynchronous reset in the middle of the payload
    tbit_period = 20'd100;
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00); send_byte(8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ok", {31'd0, frame_ok}, 32'd0);
    check("arst_total", rx_total, 32'd0);
    check("arst_err", rx_err, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send_byte(8'hA5); send_byte(8'h04);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h06);
    tick();
    check("post_rst_total", rx_total, 32'd1);
    check("post_rst_ok", {31'd0, frame_ok}, 32'd1);

    // Saturation of the good-frame counter
    force dut.total_q = 32'hFFFF_FFFE;
    tick();
    release dut.total_q;
    tick();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    tick();
    check("sat1_total", rx_total, 32'hFFFF_FFFF);
    d0 = done_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    tick();
    check("sat2_total", rx_total, 32'hFFFF_FFFF);
    check("sat2_done", done_cnt, d0 + 1);
    check("sat2_ok", {31'd0, frame_ok}, 32'd1);

    // clr coincident with the terminating byte
    send_byte(8'hA5); send_byte(8'h00);
    tick();
    check("preclr_err", rx_err, 32'd1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    d0 = done_cnt;
    clr = 1'b1;
    send_byte(8'h00);
    clr = 1'b0;
    tick();
    check("clr_done", done_cnt, d0);
    check("clr_total", rx_total, 32'd0);
    check("clr_err", rx_err, 32'd0);
    check("clr_ok", {31'd0, frame_ok}, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd0);

    // Normal operation resumes after clr
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    tick();
    check("postclr_total", rx_total, 32'd1);
    check("postclr_err", rx_err, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
